// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers producer samples in a small FIFO and hands them
// one at a time to the sequential 16-tap FIR, waiting for its completion
// strobe before issuing the next sample.
// Optional watchdog on the FIR completion: define FIR_SAMPLE_FEEDER_TIMEOUT_EN.
module fir_sample_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [WIDTH-1:0]           fir_in,
  output logic                       fir_input_ready,
  input  logic                       fir_output_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic [15:0]                issued_count,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Occupancy is the registered level, so a word pushed into an empty FIFO
  // cannot be popped on the same edge (no fall-through).
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  // A pop only happens when the FSM moves into ISSUE.
  assign pop     = !empty && ((state == IDLE) ||
                              ((state == WAIT) && fir_output_ready));

`ifdef FIR_SAMPLE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] wait_cnt;
`else
  // Watchdog not built; the flag is constant low for any legal TIMEOUT.
  assign timeout_err = (TIMEOUT < 0);
`endif

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge ck) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Issue FSM with registered strobe, data word, busy flag and completion count.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fir_in          <= '0;
      fir_input_ready <= 1'b0;
      busy            <= 1'b0;
      issued_count    <= '0;
`ifdef FIR_SAMPLE_FEEDER_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      fir_input_ready <= 1'b0;
      if (pop) begin
        fir_in <= mem[rd_ptr];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state           <= ISSUE;
            fir_input_ready <= 1'b1;
            busy            <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef FIR_SAMPLE_FEEDER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (fir_output_ready) begin
            issued_count <= issued_count + 16'd1;
            if (pop) begin
              state           <= ISSUE;
              fir_input_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
`ifdef FIR_SAMPLE_FEEDER_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed self-checking bench for fir_sample_feeder
// with hand-computed expectations; the watchdog section follows whether
// FIR_SAMPLE_FEEDER_TIMEOUT_EN is defined.
module tb_fir_sample_feeder;

  logic        ck;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] fir_in;
  logic        fir_input_ready;
  logic        fir_output_ready;
  logic [3:0]  level;
  logic        busy;
  logic [15:0] issued_count;
  logic        timeout_err;

  int checks;
  int errors;
  int strobe_count;

  fir_sample_feeder #(
    .WIDTH(16),
    .DEPTH(8),
    .TIMEOUT(32)
  ) dut (
    .ck(ck),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .fir_in(fir_in),
    .fir_input_ready(fir_input_ready),
    .fir_output_ready(fir_output_ready),
    .level(level),
    .busy(busy),
    .issued_count(issued_count),
    .timeout_err(timeout_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Count strobe cycles, sampled mid-cycle.
  always @(negedge ck) begin
    if (fir_input_ready === 1'b1) begin
      strobe_count = strobe_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] data);
    s_data  = data;
    s_valid = 1'b1;
    @(posedge ck);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pulseDone();
    fir_output_ready = 1'b1;
    @(posedge ck);
    #1;
    fir_output_ready = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    strobe_count     = 0;
    rst              = 1'b1;
    s_data           = 16'h0;
    s_valid          = 1'b0;
    fir_output_ready = 1'b0;

    // Reset state, then idle for 20 cycles
    step(2);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_strobe", 32'(fir_input_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(issued_count), 32'd0);
    checkOutput("rst_fir_in", 32'(fir_in), 32'd0);
    checkOutput("rst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step(20);
    checkOutput("idle_strobes", 32'(strobe_count), 32'd0);
    checkOutput("idle_level", 32'(level), 32'd0);
    checkOutput("idle_s_ready", 32'(s_ready), 32'd1);
    checkOutput("idle_count", 32'(issued_count), 32'd0);

    // Single sample: strobe exactly one cycle after the push edge
    applyStimulus(16'h1234);
    checkOutput("single_level", 32'(level), 32'd1);
    checkOutput("single_no_fallthru", 32'(fir_input_ready), 32'd0);
    step(1);
    checkOutput("single_strobe", 32'(fir_input_ready), 32'd1);
    checkOutput("single_fir_in", 32'(fir_in), 32'h1234);
    checkOutput("single_busy", 32'(busy), 32'd1);
    step(1);
    checkOutput("single_strobe_off", 32'(fir_input_ready), 32'd0);
    step(17);
    checkOutput("single_hold", 32'(fir_in), 32'h1234);
    checkOutput("single_wait_count", 32'(issued_count), 32'd0);
    pulseDone();
    checkOutput("single_count", 32'(issued_count), 32'd1);
    checkOutput("single_idle", 32'(busy), 32'd0);
    checkOutput("single_hold2", 32'(fir_in), 32'h1234);
    checkOutput("single_strobes", 32'(strobe_count), 32'd1);

    // Fill and backpressure: 10 offered, first popped, 8 buffered, last refused
    for (int i = 0; i < 10; i++) begin
      s_data  = 16'hA000 + 16'(i);
      s_valid = 1'b1;
      @(posedge ck);
      #1;
    end
    s_valid = 1'b0;
    checkOutput("fill_level", 32'(level), 32'd8);
    checkOutput("fill_s_ready", 32'(s_ready), 32'd0);
    checkOutput("fill_fir_in", 32'(fir_in), 32'hA000);
    checkOutput("fill_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 9; k++) begin
      pulseDone();
      if (k < 8) begin
        checkOutput("b2b_strobe", 32'(fir_input_ready), 32'd1);
        checkOutput("b2b_data", 32'(fir_in), 32'hA001 + 32'(k));
        step(1);
      end else begin
        checkOutput("drain_strobe", 32'(fir_input_ready), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);
      end
    end
    checkOutput("drain_count", 32'(issued_count), 32'd10);
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_strobes", 32'(strobe_count), 32'd10);

    // Simultaneous push and pop with three words buffered
    for (int i = 0; i < 4; i++) begin
      s_data  = 16'hB000 + 16'(i);
      s_valid = 1'b1;
      @(posedge ck);
      #1;
    end
    s_valid = 1'b0;
    checkOutput("sim_pre_level", 32'(level), 32'd3);
    s_data           = 16'hB004;
    s_valid          = 1'b1;
    fir_output_ready = 1'b1;
    @(posedge ck);
    #1;
    s_valid          = 1'b0;
    fir_output_ready = 1'b0;
    checkOutput("sim_level", 32'(level), 32'd3);
    checkOutput("sim_fir_in", 32'(fir_in), 32'hB001);
    checkOutput("sim_strobe", 32'(fir_input_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      pulseDone();
      if (k < 3) begin
        checkOutput("sim_order", 32'(fir_in), 32'hB002 + 32'(k));
      end else begin
        checkOutput("sim_end_busy", 32'(busy), 32'd0);
        checkOutput("sim_end_level", 32'(level), 32'd0);
      end
    end
    checkOutput("sim_count", 32'(issued_count), 32'd15);

    // Stray completions in IDLE and ISSUE are ignored
    pulseDone();
    checkOutput("stray_idle_count", 32'(issued_count), 32'd15);
    checkOutput("stray_idle_busy", 32'(busy), 32'd0);
    applyStimulus(16'hC000);
    step(1);
    checkOutput("stray_issue_strobe", 32'(fir_input_ready), 32'd1);
    pulseDone();
    checkOutput("stray_issue_count", 32'(issued_count), 32'd15);
    checkOutput("stray_issue_busy", 32'(busy), 32'd1);

    // Asynchronous reset in WAIT with five words buffered
    for (int i = 1; i < 6; i++) begin
      applyStimulus(16'hC000 + 16'(i));
    end
    checkOutput("pre_rst_level", 32'(level), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_level", 32'(level), 32'd0);
    checkOutput("arst_strobe", 32'(fir_input_ready), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_count", 32'(issued_count), 32'd0);
    checkOutput("arst_s_ready", 32'(s_ready), 32'd1);
    s_data  = 16'hDEAD;
    s_valid = 1'b1;
    @(posedge ck);
    #1;
    checkOutput("rst_push_ignored", 32'(level), 32'd0);
    s_valid = 1'b0;
    rst     = 1'b0;
    step(2);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    // Watchdog: sample issued, completion never returned
    applyStimulus(16'h0D00);
    step(33);
    checkOutput("wd_pre_busy", 32'(busy), 32'd1);
    checkOutput("wd_pre_terr", 32'(timeout_err), 32'd0);
    step(1);
`ifdef FIR_SAMPLE_FEEDER_TIMEOUT_EN
    checkOutput("wd_terr", 32'(timeout_err), 32'd1);
    checkOutput("wd_idle", 32'(busy), 32'd0);
    checkOutput("wd_count", 32'(issued_count), 32'd0);
    step(3);
    checkOutput("wd_sticky", 32'(timeout_err), 32'd1);
`else
    checkOutput("wd_off_terr", 32'(timeout_err), 32'd0);
    checkOutput("wd_off_busy", 32'(busy), 32'd1);
    step(3);
    checkOutput("wd_off_still_wait", 32'(busy), 32'd1);
    checkOutput("wd_off_count", 32'(issued_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Upstream-side driver for the 16-tap sequential FIR filter.
- Accepts samples from a producer over a valid/ready stream and buffers them in a small FIFO.
- Presents one sample at a time to the FIR as a data word plus a one-cycle input_ready strobe, then waits for the FIR's output_ready before issuing the next sample.
- Guarantees the FIR is never overrun and that its input word stays stable while the FIR latches it.

Parameters:
- WIDTH, 16, sample width in bits (matches FIR sample width).
- DEPTH, 8, FIFO depth in samples; power of 2, >= 2.
- TIMEOUT, 32, max cycles to wait for fir_output_ready (used only with the optional feature).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  WIDTH  signed sample from producer.
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder can accept; equals !full.
- fir_in  out  WIDTH  signed sample to FIR `in`; registered.
- fir_input_ready  out  1  one-cycle strobe to FIR input_ready; registered.
- fir_output_ready  in  1  FIR completion strobe.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- busy  out  1  high in ISSUE or WAIT.
- issued_count  out  16  completed FIR operations, modulo 2^16.
- timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset: state IDLE, FIFO flushed, level=0, fir_in=0, fir_input_ready=0, busy=0, issued_count=0, timeout_err=0. s_ready is combinational !full, so it reads 1 during and after reset. Pushes are ignored while rst=1.
- Reset mid-operation clears all of the above immediately (async). The FIR shares rst, so no handshake is left pending.
- FIFO push: on an edge where s_valid && s_ready. Full means no push (no bypass).
- FIFO pop: only on the IDLE->ISSUE or WAIT->ISSUE transition; the head word is written into fir_in on that edge.
- Simultaneous push and pop: level is unchanged, data order is preserved.
- No fall-through: a word pushed into an empty FIFO on edge E is popped no earlier than edge E+1.
- Pointers wrap modulo DEPTH.
- FSM IDLE: fir_input_ready=0. If level>0, pop and go to ISSUE.
- FSM ISSUE: fir_input_ready=1 for exactly this one cycle, then go to WAIT unconditionally.
- FSM WAIT: fir_in is held stable. On fir_output_ready:
  - issued_count increments (0xFFFF wraps to 0x0000).
  - If level>0, pop and go directly to ISSUE; otherwise go to IDLE.
- fir_output_ready seen in IDLE or ISSUE is ignored: no count change, no state change.
- fir_in changes only on a pop edge and is constant from the ISSUE cycle until the next pop.
- Latency: sample accepted on edge E into an idle, empty feeder gives fir_input_ready high for the cycle between edges E+1 and E+2.
- Back-to-back: fir_output_ready high in cycle t with FIFO non-empty gives fir_input_ready high in cycle t+1. This lands in the FIR's waiting state.

Optional Feature:
- Macro: FIR_SAMPLE_FEEDER_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT and resets on entry to WAIT. If it reaches TIMEOUT without fir_output_ready, the feeder:
  - sets timeout_err (sticky until rst);
  - goes to IDLE without incrementing issued_count;
  - drops the sample.
- A fir_output_ready on the same cycle as the count reaching TIMEOUT takes priority: normal completion, no error.
- Not defined: no counter is built, WAIT waits indefinitely, timeout_err is tied 0.

Test Plan:
- Reset then idle: rst pulse, no stimulus for 20 cycles -> level=0, s_ready=1, fir_input_ready never asserted, issued_count=0.
- Single sample: push 0x1234 on edge E; responder returns fir_output_ready 19 cycles after the strobe -> fir_input_ready high only in cycle E+1..E+2, fir_in=0x1234 until the next pop, issued_count=1, FSM back in IDLE.
- Fill and backpressure: DEPTH=8, responder stalled, push 10 samples -> first popped; 8 buffered, s_ready=0, level=8. Release responder -> all 9 issued in order with each fir_input_ready strobe one cycle after the prior fir_output_ready; issued_count=9.
- Simultaneous push/pop: level=3, push on the same edge as WAIT->ISSUE pop -> level stays 3, order preserved.
- Stray and reset: fir_output_ready pulsed in IDLE -> issued_count unchanged. Assert rst during WAIT with level=5 -> level=0, fir_input_ready=0 immediately, busy=0.
- Timeout (macro defined, TIMEOUT=32): issue a sample, never return fir_output_ready -> timeout_err=1 at cycle 32 of WAIT, FSM IDLE, issued_count=0. With the macro undefined, the feeder stays in WAIT and timeout_err=0.
